// File: rtl/spi_master16.sv
// spi_master16: mode-0, MSB-first, 16-bit SPI initiator with a valid/ready word handshake.
// Build option: define SPI_MASTER16_LOOPBACK_EN to feed the rx shifter from the mosi register.
//
// state | meaning
// IDLE  | tx_ready high, waiting for tx_valid
// SETUP | cs_n low, bit15 on mosi, one half-period before the first SCK rise
// SHIFT | 31 SCK half-periods; the 16th falling edge leaves for HOLD
// HOLD  | SCK low for the final half-period, then cs_n rises and rx_data updates
// GAP   | cs_n high for CS_GAP cycles before the next frame may start
`timescale 1ns/1ps
module spi_master16 #(
    parameter int CLK_DIV = 12,
    parameter int CS_GAP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);

    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(CS_GAP - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [4:0]    bit_q, bit_d;
    logic [15:0]   tx_sh_q, tx_sh_d;
    logic [15:0]   rx_sh_q, rx_sh_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          cs_n_q, cs_n_d;
    logic [15:0]   rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          div_tc;
    logic          miso_s;

`ifdef SPI_MASTER16_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = spi_miso;
    assign miso_s      = mosi_q;
`else
    assign miso_s      = spi_miso;
`endif

    assign div_tc = (div_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;
        ready_d    = ready_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid && ready_q) begin
                    state_d = ST_SETUP;
                    div_d   = DIV_LOAD;
                    bit_d   = '0;
                    tx_sh_d = tx_data;
                    rx_sh_d = '0;
                    mosi_d  = tx_data[15];
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (div_tc) begin
                    state_d = ST_SHIFT;
                    div_d   = DIV_LOAD;
                    bit_d   = '0;
                    sck_d   = 1'b1;
                    rx_sh_d = {rx_sh_q[14:0], miso_s};
                end else begin
                    div_d = div_q - CW'(1);
                end
            end
            ST_SHIFT: begin
                if (div_tc) begin
                    div_d = DIV_LOAD;
                    bit_d = bit_q + 5'd1;
                    if (sck_q) begin
                        sck_d = 1'b0;
                        // Even half-periods are SCK-high; the end of half-period 30 is the 16th fall.
                        if (bit_q == 5'd30) begin
                            state_d = ST_HOLD;
                        end else begin
                            tx_sh_d = {tx_sh_q[14:0], 1'b0};
                            mosi_d  = tx_sh_q[14];
                        end
                    end else begin
                        sck_d   = 1'b1;
                        rx_sh_d = {rx_sh_q[14:0], miso_s};
                    end
                end else begin
                    div_d = div_q - CW'(1);
                end
            end
            ST_HOLD: begin
                if (div_tc) begin
                    state_d    = ST_GAP;
                    div_d      = GAP_LOAD;
                    cs_n_d     = 1'b1;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                end else begin
                    div_d = div_q - CW'(1);
                end
            end
            ST_GAP: begin
                if (div_tc) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    div_d = div_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx_ready = ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master16.sv
// Self-checking bench for spi_master16: a CLK_DIV=12/CS_GAP=4 instance and a CLK_DIV=1/CS_GAP=1 instance,
// each with a mode-0 responder model that also captures mosi on SCK rises.
`timescale 1ns/1ps
module tb_spi_master16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [15:0] td_m, rd_m, td_f, rd_f;
    logic        tv_m, tr_m, rv_m, busy_m, sck_m, mosi_m, miso_m, cs_m;
    logic        tv_f, tr_f, rv_f, busy_f, sck_f, mosi_f, miso_f, cs_f;

    spi_master16 #(.CLK_DIV(12), .CS_GAP(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .tx_data(td_m), .tx_valid(tv_m), .tx_ready(tr_m),
        .rx_data(rd_m), .rx_valid(rv_m), .busy(busy_m), .spi_sck(sck_m),
        .spi_mosi(mosi_m), .spi_miso(miso_m), .spi_cs_n(cs_m)
    );

    spi_master16 #(.CLK_DIV(1), .CS_GAP(1)) u_fast (
        .clk(clk), .rst_n(rst_n), .tx_data(td_f), .tx_valid(tv_f), .tx_ready(tr_f),
        .rx_data(rd_f), .rx_valid(rv_f), .busy(busy_f), .spi_sck(sck_f),
        .spi_mosi(mosi_f), .spi_miso(miso_f), .spi_cs_n(cs_f)
    );

    // Responder models: bit15 out when cs_n falls, next bit after every SCK fall.
    logic [15:0] resp_m = '0, cap_m = '0, resp_f = '0, cap_f = '0;
    logic [3:0]  nf_m = '0, nf_f = '0;
    always @(negedge sck_m or posedge cs_m) begin
        if (cs_m) nf_m = '0;
        else if (nf_m != 4'd15) nf_m = nf_m + 4'd1;
    end
    always @(negedge sck_f or posedge cs_f) begin
        if (cs_f) nf_f = '0;
        else if (nf_f != 4'd15) nf_f = nf_f + 4'd1;
    end
    assign miso_m = resp_m[4'd15 - nf_m];
    assign miso_f = resp_f[4'd15 - nf_f];
    always @(posedge sck_m) cap_m = {cap_m[14:0], mosi_m};
    always @(posedge sck_f) cap_f = {cap_f[14:0], mosi_f};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_rx(input logic [15:0] tx, input logic [15:0] resp);
`ifdef SPI_MASTER16_LOOPBACK_EN
        return tx;
`else
        return resp;
`endif
    endfunction

    // One frame with full timing checks; cycle n counts from the accept cycle (n=0).
    task automatic run_frame(input bit fast, input logic [15:0] tx, input logic [15:0] resp,
                             input logic [15:0] exp, input int poke_n, input string tag);
        int div, gap, base, n;
        int cs_fall_n, rise1_n, cs_low, cs_rise_n, rv_cnt, rv_n, ready_n;
        logic [15:0] rv_data, s_rd;
        logic s_cs, s_sck, s_rv, s_tr, s_busy;
        bit done;
        div = fast ? 1 : 12;
        gap = fast ? 1 : 4;
        cs_fall_n = -1; rise1_n = -1; cs_rise_n = -1; rv_n = -1; ready_n = -1;
        cs_low = 0; rv_cnt = 0; rv_data = '0; s_busy = 1'b1; s_rd = '0;
        if (fast) resp_f = resp; else resp_m = resp;
        @(negedge clk);
        check({tag, "_ready_pre"}, 32'(fast ? tr_f : tr_m), 1);
        if (fast) begin tv_f = 1'b1; td_f = tx; end
        else begin tv_m = 1'b1; td_m = tx; end
        @(posedge clk);
        @(negedge clk);
        if (fast) begin tv_f = 1'b0; td_f = ~tx; end
        else begin tv_m = 1'b0; td_m = ~tx; end
        base = cyc - 1;
        done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            if (i > 0) @(negedge clk);
            n = cyc - base;
            if (poke_n > 0 && n == poke_n) begin
                if (fast) begin tv_f = 1'b1; td_f = 16'h5555; end
                else begin tv_m = 1'b1; td_m = 16'h5555; end
            end
            if (poke_n > 0 && n == poke_n + 1) begin
                if (fast) tv_f = 1'b0; else tv_m = 1'b0;
            end
            s_cs   = fast ? cs_f   : cs_m;
            s_sck  = fast ? sck_f  : sck_m;
            s_rv   = fast ? rv_f   : rv_m;
            s_tr   = fast ? tr_f   : tr_m;
            s_busy = fast ? busy_f : busy_m;
            s_rd   = fast ? rd_f   : rd_m;
            if (n == 1) begin
                check({tag, "_busy_c1"}, 32'(s_busy), 1);
                check({tag, "_ready_c1"}, 32'(s_tr), 0);
            end
            if (!s_cs) begin
                cs_low++;
                if (cs_fall_n < 0) cs_fall_n = n;
            end else if (cs_fall_n >= 0 && cs_rise_n < 0) begin
                cs_rise_n = n;
            end
            if (s_sck && rise1_n < 0) rise1_n = n;
            if (s_rv) begin rv_cnt++; rv_n = n; rv_data = s_rd; end
            if (s_tr && n > 1) begin ready_n = n; done = 1; end
        end
        check({tag, "_completed"}, 32'(done), 1);
        check({tag, "_cs_fall"}, cs_fall_n, 1);
        check({tag, "_first_rise"}, rise1_n, 1 + div);
        check({tag, "_cs_low_cycles"}, cs_low, 33 * div);
        check({tag, "_cs_rise"}, cs_rise_n, 1 + 33 * div);
        check({tag, "_rv_count"}, rv_cnt, 1);
        check({tag, "_rv_cycle"}, rv_n, 1 + 33 * div);
        check({tag, "_rx_data"}, 32'(rv_data), 32'(exp));
        check({tag, "_rx_hold"}, 32'(s_rd), 32'(exp));
        check({tag, "_ready_cycle"}, ready_n, 1 + 33 * div + gap);
        check({tag, "_busy_end"}, 32'(s_busy), 0);
        check({tag, "_mosi_word"}, 32'(fast ? cap_f : cap_m), 32'(tx));
    endtask

    typedef struct {
        logic [15:0] tx;
        logic [15:0] resp;
        logic [15:0] exp;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        logic [15:0] words[3];
        int rises, k, nrv, nfr, hi_run;
        logic prev, prev_cs, acc_pend;
        bit reached, fin;

        vecs[0] = '{16'hA55A, 16'h3C0F, exp_rx(16'hA55A, 16'h3C0F)};
        vecs[1] = '{16'h1234, 16'h8001, exp_rx(16'h1234, 16'h8001)};
        vecs[2] = '{16'hFFFE, 16'h0000, exp_rx(16'hFFFE, 16'h0000)};
        vecs[3] = '{16'h0001, 16'hFFFF, exp_rx(16'h0001, 16'hFFFF)};
        words[0] = 16'h0F0F; words[1] = 16'hF0F1; words[2] = 16'h7E81;

        rst_n = 1'b0;
        tv_m = 1'b0; td_m = '0; tv_f = 1'b0; td_f = '0;
        repeat (3) @(negedge clk);
        check("rst_sck", 32'(sck_m), 0);
        check("rst_cs_n", 32'(cs_m), 1);
        check("rst_mosi", 32'(mosi_m), 0);
        check("rst_rx_data", 32'(rd_m), 0);
        check("rst_rx_valid", 32'(rv_m), 0);
        check("rst_busy", 32'(busy_m), 0);
        check("rst_tx_ready", 32'(tr_m), 1);
        rst_n = 1'b1;

        // Abort a frame with reset at the 7th SCK rise.
        resp_m = 16'hFFFF;
        @(negedge clk);
        tv_m = 1'b1; td_m = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        tv_m = 1'b0;
        rises = 0; prev = 1'b0; reached = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sck_m && !prev) rises++;
            prev = sck_m;
            if (rises == 7) begin reached = 1; break; end
        end
        check("abort_reached_rise7", 32'(reached), 1);
        rst_n = 1'b0;
        #1;
        check("abort_sck", 32'(sck_m), 0);
        check("abort_cs_n", 32'(cs_m), 1);
        check("abort_busy", 32'(busy_m), 0);
        check("abort_rx_valid", 32'(rv_m), 0);
        check("abort_rx_data", 32'(rd_m), 0);
        @(negedge clk);
        check("abort_hold_rx_valid", 32'(rv_m), 0);
        rst_n = 1'b1;
        run_frame(0, 16'h00FF, 16'h5AA5, exp_rx(16'h00FF, 16'h5AA5), 0, "after_abort");

        for (int v = 0; v < 4; v++)
            run_frame(0, vecs[v].tx, vecs[v].resp, vecs[v].exp, 0, $sformatf("vec%0d", v));

        // Back-to-back: tx_valid held through three frames.
        resp_m = 16'hC001;
        @(negedge clk);
        tv_m = 1'b1; td_m = words[0];
        acc_pend = tr_m;
        k = 0; nrv = 0; nfr = 0; hi_run = 0; prev_cs = cs_m; fin = 0;
        for (int i = 0; i < 2000 && !fin; i++) begin
            @(negedge clk);
            if (acc_pend) begin
                k++;
                if (k < 3) td_m = words[k]; else tv_m = 1'b0;
            end
            if (cs_m) begin
                hi_run++;
                if (!prev_cs) begin
                    check($sformatf("b2b_mosi%0d", nfr), 32'(cap_m), 32'(words[nfr < 3 ? nfr : 2]));
                    nfr++;
                end
            end else begin
                if (prev_cs && nfr > 0)
                    check($sformatf("b2b_gap%0d", nfr), hi_run, 4 + 1);
                hi_run = 0;
            end
            if (rv_m) begin
                check($sformatf("b2b_rx%0d", nrv), 32'(rd_m), 32'(exp_rx(words[nrv < 3 ? nrv : 2], 16'hC001)));
                nrv++;
            end
            prev_cs = cs_m;
            acc_pend = tr_m && tv_m;
            if (nrv == 3 && tr_m) fin = 1;
        end
        check("b2b_completed", 32'(fin), 1);
        check("b2b_accepts", k, 3);
        check("b2b_frames", nfr, 3);
        check("b2b_rv_count", nrv, 3);

        // New tx_valid while busy must be ignored and must not queue a frame.
        run_frame(0, 16'hC3C3, 16'h0F0F, exp_rx(16'hC3C3, 16'h0F0F), 100, "busy_poke");
        hi_run = 0;
        repeat (50) begin
            @(negedge clk);
            if (!cs_m) hi_run++;
        end
        check("busy_poke_no_extra_frame", hi_run, 0);

        // Fastest divider, responder echoing the word.
        run_frame(1, 16'h8001, 16'h8001, 16'h8001, 0, "fast");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
